// File: rtl/ifetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch_unit: PC, word-addressed IMEM, next-PC resolution, run/halt.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ifetch_unit #(
   parameter int unsigned IMEM_DEPTH  = 256,
   parameter int unsigned AW          = 8,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_we_i,
   input  logic [AW-1:0] load_addr_i,
   input  logic [31:0]   load_data_i,
   input  logic          start_i,
   input  logic [2:0]    br_type_i,
   input  logic          jump_i,
   input  logic          zero_i,
   input  logic          msb_i,
   output logic [31:0]   inst_o,
   output logic [31:0]   pc_o,
   output logic [31:0]   pc_plus4_o,
   output logic          taken_o,
   output logic          running_o,
   output logic          halted_o,
   output logic [31:0]   retired_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] retired_q, retired_d;
   logic [31:0] imem_q [IMEM_DEPTH];

   logic        is_halt;
   logic        br_cond;
   logic [31:0] br_target;
   logic [31:0] jmp_target;

   // IMEM is deliberately left out of reset so a program survives a reset.
   always_ff @(posedge clk) begin
      if (load_we_i && (state_q != ST_RUN)) begin
         imem_q[load_addr_i] <= load_data_i;
      end
   end

   assign running_o  = (state_q == ST_RUN);
   assign halted_o   = (state_q == ST_HALT);
   assign pc_o       = pc_q;
   assign pc_plus4_o = pc_q + 32'd4;
   assign retired_o  = retired_q;

   // Out-of-range fetches and all non-RUN cycles present a NOP.
   always_comb begin
      inst_o = 32'h0;
      if (running_o && (pc_q[31:AW+2] == '0)) begin
         inst_o = imem_q[pc_q[AW+1:2]];
      end
   end

   always_comb begin
      br_cond = 1'b0;
      case (br_type_i)
         3'd1:    br_cond = zero_i;
         3'd2:    br_cond = !zero_i;
         3'd3:    br_cond = msb_i;
         3'd4:    br_cond = !msb_i;
         3'd5:    br_cond = msb_i | zero_i;
         3'd6:    br_cond = !msb_i & !zero_i;
         default: br_cond = 1'b0;
      endcase
   end

   assign is_halt    = (inst_o[31:26] == HALT_OPCODE);
   assign taken_o    = running_o & !is_halt & (jump_i | br_cond);
   assign br_target  = pc_plus4_o + {{14{inst_o[15]}}, inst_o[15:0], 2'b00};
   assign jmp_target = {pc_plus4_o[31:28], inst_o[25:0], 2'b00};

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      retired_d = retired_q;
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start_i) begin
               state_d   = ST_RUN;
               pc_d      = RESET_PC;
               retired_d = 32'h0;
            end
         end
         ST_RUN: begin
            if (is_halt) begin
               state_d = ST_HALT;
            end else begin
               if (jump_i) begin
                  pc_d = jmp_target;
               end else if (br_cond) begin
                  pc_d = br_target;
               end else begin
                  pc_d = pc_plus4_o;
               end
               retired_d = retired_q + 32'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         retired_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         retired_q <= retired_d;
      end
   end

endmodule
`default_nettype wire
